// File: rtl/pt_fifo_pkg.sv
// Shared types and helpers for the pt_fifo family: count-width sizing and a
// status bundle for downstream aggregation of FIFO telemetry.
package pt_fifo_pkg;

  localparam int unsigned StatusLevelW = 16;

  // Width needed to hold any occupancy value 0..depth inclusive.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [StatusLevelW-1:0] level;
    logic                    full;
    logic                    empty;
    logic                    hwm;
    logic                    lwm;
  } fifo_status_t;

endpackage

// File: rtl/pt_fifo_out_reg.sv
// Registered read stage for pt_fifo_flex: holds the head entry in flops and
// refills from the storage array, or from the write port when the array is empty.
module pt_fifo_out_reg
  import pt_fifo_pkg::*;
#(
  parameter type DATA_T = logic [31:0]
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  load,
  input  logic  arr_nonempty,
  input  DATA_T arr_head,
  input  logic  push,
  input  DATA_T wr_data,
  output logic  out_vld,
  output DATA_T out_dat
);

  logic  out_vld_q;
  DATA_T out_dat_q;

  // Array head has priority so ordering stays FIFO; the write port only
  // bypasses into the register when nothing older is queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else if (flush) begin
      out_vld_q <= 1'b0;
    end else if (load) begin
      if (arr_nonempty) begin
        out_vld_q <= 1'b1;
        out_dat_q <= arr_head;
      end else if (push) begin
        out_vld_q <= 1'b1;
        out_dat_q <= wr_data;
      end else begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;

endmodule

// File: rtl/pt_fifo_flex.sv
// Valid/ready FIFO with optional registered read port, programmable
// watermarks, synchronous flush and peak-occupancy tracking.
module pt_fifo_flex
  import pt_fifo_pkg::*;
#(
  parameter type         DATA_T  = logic [31:0],
  parameter int unsigned DEPTH   = 8,
  parameter bit          REG_OUT = 1'b0,
  localparam int unsigned COUNT_W = count_w(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  DATA_T              i_wr_data,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  output DATA_T              o_rd_data,
  output logic               o_rd_valid,
  input  logic               i_rd_ready,
  input  logic               i_flush,
  input  logic [COUNT_W-1:0] i_hwm,
  input  logic [COUNT_W-1:0] i_lwm,
  input  logic               i_clr_peak,
  output logic [COUNT_W-1:0] o_level,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_hwm,
  output logic               o_lwm,
  output logic [COUNT_W-1:0] o_peak
);

  localparam int unsigned         PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]   LAST_P  = PTR_W'(DEPTH - 1);

  DATA_T              mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [COUNT_W-1:0] level_q, level_d;
  logic [COUNT_W-1:0] peak_q, peak_d;
  logic               push, pop;
  logic               arr_push, arr_pop;
  DATA_T              arr_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full     = (level_q == DEPTH_C);
  assign o_empty    = (level_q == '0);
  assign o_wr_ready = !o_full && !i_flush;
  assign push       = i_wr_valid && o_wr_ready;
  assign pop        = o_rd_valid && i_rd_ready;
  assign arr_head   = mem_q[tail_q];

  if (REG_OUT) begin : g_reg_out
    logic [COUNT_W-1:0] arr_cnt;
    logic               arr_nonempty;
    logic               load;
    logic               out_vld;
    DATA_T              out_dat;

    // Occupancy counts the output register, so the array holds the rest.
    assign arr_cnt      = level_q - COUNT_W'(out_vld);
    assign arr_nonempty = (arr_cnt != '0);
    assign load         = !out_vld || pop;
    assign arr_pop      = load && arr_nonempty;
    assign arr_push     = push && !(load && !arr_nonempty);

    pt_fifo_out_reg #(
      .DATA_T(DATA_T)
    ) u_out_reg (
      .clk         (i_clk),
      .rst_n       (i_rst_n),
      .flush       (i_flush),
      .load        (load),
      .arr_nonempty(arr_nonempty),
      .arr_head    (arr_head),
      .push        (push),
      .wr_data     (i_wr_data),
      .out_vld     (out_vld),
      .out_dat     (out_dat)
    );

    assign o_rd_valid = out_vld;
    assign o_rd_data  = out_dat;
  end else begin : g_comb_out
    assign arr_pop    = pop;
    assign arr_push   = push;
    assign o_rd_valid = !o_empty;
    assign o_rd_data  = arr_head;
  end

  always_comb begin
    level_d = i_flush ? '0 : level_q + COUNT_W'(push) - COUNT_W'(pop);
    if (i_clr_peak) begin
      peak_d = level_d;
    end else begin
      peak_d = (level_d > peak_q) ? level_d : peak_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      peak_q  <= '0;
    end else begin
      level_q <= level_d;
      peak_q  <= peak_d;
      if (i_flush) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (arr_push) head_q <= ptr_inc(head_q);
        if (arr_pop)  tail_q <= ptr_inc(tail_q);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (arr_push) begin
      mem_q[head_q] <= i_wr_data;
    end
  end

  assign o_level = level_q;
  assign o_peak  = peak_q;
  assign o_hwm   = (level_q >= i_hwm);
  assign o_lwm   = (level_q <= i_lwm);

endmodule

// File: tb/tb_pt_fifo_flex.sv
// Drives a combinational-read and a registered-read instance with identical
// stimulus and compares both against a queue-based reference model.
module tb_pt_fifo_flex;

  localparam int DEPTH = 5;
  localparam int CW    = 3;

  typedef logic [43:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   wr_data;
  logic          wr_valid, rd_ready, flush, clr_peak;
  logic [CW-1:0] hwm, lwm;

  logic [1:0]    wr_ready, rd_valid, full, empty, hwm_flag, lwm_flag;
  logic [31:0]   rd_data [2];
  logic [CW-1:0] level [2];
  logic [CW-1:0] peak [2];

  logic [31:0]   q [$];
  int            peak_m;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  pt_fifo_flex #(.DATA_T(logic [31:0]), .DEPTH(DEPTH), .REG_OUT(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_data(wr_data), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready[0]), .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]),
    .i_rd_ready(rd_ready), .i_flush(flush), .i_hwm(hwm), .i_lwm(lwm),
    .i_clr_peak(clr_peak), .o_level(level[0]), .o_full(full[0]), .o_empty(empty[0]),
    .o_hwm(hwm_flag[0]), .o_lwm(lwm_flag[0]), .o_peak(peak[0])
  );

  pt_fifo_flex #(.DATA_T(logic [31:0]), .DEPTH(DEPTH), .REG_OUT(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_data(wr_data), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready[1]), .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]),
    .i_rd_ready(rd_ready), .i_flush(flush), .i_hwm(hwm), .i_lwm(lwm),
    .i_clr_peak(clr_peak), .o_level(level[1]), .o_full(full[1]), .o_empty(empty[1]),
    .o_hwm(hwm_flag[1]), .o_lwm(lwm_flag[1]), .o_peak(peak[1])
  );

  // Expected outputs from queue contents; payload only meaningful when valid.
  function automatic vec_t exp_vec();
    int          lv;
    logic [31:0] d;
    lv = q.size();
    d  = (lv > 0) ? q[0] : 32'h0;
    return {lv > 0, d, (lv < DEPTH) && !flush, lv == DEPTH, lv == 0,
            lv >= int'(hwm), lv <= int'(lwm), 3'(lv), 3'(peak_m)};
  endfunction

  function automatic vec_t obs_vec(input int m);
    return {rd_valid[m], rd_valid[m] ? rd_data[m] : 32'h0, wr_ready[m], full[m], empty[m],
            hwm_flag[m], lwm_flag[m], level[m], peak[m]};
  endfunction

  task automatic drive(input logic wv, input logic [31:0] wd, input logic rr,
                       input logic fl, input logic cp);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    clr_peak = cp;
    #1;
  endtask

  // Advance one clock and apply the transfer rules to the model.
  task automatic tick();
    bit do_push, do_pop;
    do_push = wr_valid && (q.size() < DEPTH) && !flush;
    do_pop  = (q.size() > 0) && rd_ready;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(wr_data);
    if (flush) q.delete();
    if (clr_peak) peak_m = q.size();
    else if (q.size() > peak_m) peak_m = q.size();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    q.delete();
    peak_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (obs_vec(m) !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_state mode%0d: got %h want %h", m, obs_vec(m), exp_vec());
      end
      n_vec++;
      if (rd_data[m] !== 32'h0) begin
        n_err++;
        $display("FAIL reset_data mode%0d: got %h want 0", m, rd_data[m]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i <= DEPTH; i++) begin
      drive(1'b1, 32'h10 + i, 1'b0, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs_vec(m) !== exp_vec()) begin
          n_err++;
          $display("FAIL fill mode%0d: got %h want %h", m, obs_vec(m), exp_vec());
        end
      end
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (rd_valid[m] !== 1'b1 || rd_data[m] !== 32'h10 + i) begin
          n_err++;
          $display("FAIL drain_order mode%0d: got %b/%h want 1/%h", m, rd_valid[m],
                   rd_data[m], 32'h10 + i);
        end
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (obs_vec(m) !== exp_vec()) begin
        n_err++;
        $display("FAIL drained mode%0d: got %h want %h", m, obs_vec(m), exp_vec());
      end
    end
  endtask

  task automatic test_latency();
    drive(1'b1, 32'hAB, 1'b1, 1'b0, 1'b0);
    for (int step = 0; step < 3; step++) begin
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs_vec(m) !== exp_vec()) begin
          n_err++;
          $display("FAIL latency%0d mode%0d: got %h want %h", step, m, obs_vec(m), exp_vec());
        end
      end
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] d;
    d = 32'h100;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, d, 1'b0, 1'b0, 1'b0);
      d++;
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, d, 1'b1, 1'b0, 1'b0);
      d++;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs_vec(m) !== exp_vec() || level[m] !== 3'd3) begin
          n_err++;
          $display("FAIL concurrent mode%0d: got %h want %h", m, obs_vec(m), exp_vec());
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + i, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (obs_vec(m) !== exp_vec() || wr_ready[m] !== 1'b0) begin
        n_err++;
        $display("FAIL flush_cycle mode%0d: got %h want %h", m, obs_vec(m), exp_vec());
      end
    end
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (empty[m] !== 1'b1 || rd_valid[m] !== 1'b0 || peak[m] !== 3'd4) begin
        n_err++;
        $display("FAIL flush_after mode%0d: got e%b v%b p%0d want e1 v0 p4", m, empty[m],
                 rd_valid[m], peak[m]);
      end
    end
  endtask

  task automatic test_watermarks();
    apply_reset();
    hwm = 3'd3;
    lwm = 3'd1;
    for (int lv = 0; lv <= 4; lv++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs_vec(m) !== exp_vec() || hwm_flag[m] !== (lv >= 3) || lwm_flag[m] !== (lv <= 1))
        begin
          n_err++;
          $display("FAIL watermark_l%0d mode%0d: got %h want %h", lv, m, obs_vec(m), exp_vec());
        end
      end
      drive(1'b1, 32'h300 + lv, 1'b0, 1'b0, 1'b0);
      if (lv < 4) tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (peak[m] !== 3'd2 || level[m] !== 3'd2) begin
        n_err++;
        $display("FAIL clr_peak mode%0d: got peak %0d level %0d want 2 2", m, peak[m], level[m]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      hwm = 3'($urandom_range(7));
      lwm = 3'($urandom_range(7));
      drive(1'($urandom_range(1)), $urandom(), 1'($urandom_range(1)),
            $urandom_range(19) == 0, $urandom_range(15) == 0);
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs_vec(m) !== exp_vec()) begin
          n_err++;
          $display("FAIL random%0d mode%0d: got %h want %h", i, m, obs_vec(m), exp_vec());
        end
      end
      tick();
    end
    hwm = 3'd4;
    lwm = 3'd1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + i, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h403, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    q.delete();
    peak_m = 0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (obs_vec(m) !== exp_vec() || rd_data[m] !== 32'h0) begin
        n_err++;
        $display("FAIL async_reset mode%0d: got %h want %h", m, obs_vec(m), exp_vec());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (obs_vec(m) !== exp_vec() || rd_data[m] !== 32'h77) begin
        n_err++;
        $display("FAIL post_reset_push mode%0d: got %h want %h", m, obs_vec(m), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    hwm    = 3'd4;
    lwm    = 3'd1;
    peak_m = 0;
    test_reset();
    test_fill_drain();
    test_latency();
    test_concurrent();
    test_flush();
    test_watermarks();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
